// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter source: default width,
// handshake FSM states and the reference binary-to-Gray mapping.
package gray_pkg;

  localparam int GRAY_W_DEFAULT = 10;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Defined on a 32-bit word; callers truncate to their own width, which is
  // safe because the top Gray bit of a zero-extended value is the top binary bit.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/b2gnbit.sv
// Combinational N-bit binary-to-Gray converter.
module b2gnbit
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT
) (
  input  logic [N-1:0] b,
  output logic [N-1:0] g
);

  assign g = N'(bin2gray(32'(b)));

endmodule

// File: rtl/gray_cnt_src.sv
// Gray-code word source with a valid/ready handshake, load and wrap pulse.
// Define GRAY_UPDOWN_EN to add the dir port and bidirectional counting.
module gray_cnt_src
  import gray_pkg::*;
#(
  parameter int N = GRAY_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
`ifdef GRAY_UPDOWN_EN
  input  logic         dir,
`endif
  output logic [N-1:0] g,
  output logic         g_valid,
  input  logic         g_ready,
  output logic         wrap
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_MIN = '0;
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_t       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] g_d;
  logic         wrap_d;
  logic         up;
  logic         xfer;

`ifdef GRAY_UPDOWN_EN
  assign up = dir;
`else
  assign up = 1'b1;
`endif

  assign g_valid = (state_q == SEND);
  assign xfer    = g_valid && g_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (load) begin
      // Load wins over a same-cycle transfer and drops any pending word.
      cnt_d   = load_val;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en) state_d = SEND;
        end
        SEND: begin
          // Without g_ready the pending word is frozen; en cannot retract it.
          if (xfer) begin
            cnt_d  = up ? (cnt_q + CNT_ONE) : (cnt_q - CNT_ONE);
            wrap_d = up ? (cnt_q == CNT_MAX) : (cnt_q == CNT_MIN);
            if (!en) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // g is registered from the next count so it always equals bin2gray(cnt).
  b2gnbit #(.N(N)) u_b2g (
    .b (cnt_d),
    .g (g_d)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register updates from pre-edge values.
    if (!rst_n) begin
      cnt_q   <= '0;
      g       <= '0;
      state_q <= IDLE;
      wrap    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      g       <= g_d;
      state_q <= state_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_gray_cnt_src.sv
// Self-checking bench for gray_cnt_src: directed cases plus a randomized
// run scored against a word-stream model through a Gray-to-binary decoder.
module tb_gray_cnt_src;

  localparam int N = 10;
  localparam int unsigned MASK = (1 << N) - 1;
  localparam int SEQ_LEN = 4200;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         dir;
  logic [N-1:0] g;
  logic         g_valid;
  logic         g_ready;
  logic         wrap;

  int n_vec = 0;
  int n_err = 0;

  int unsigned exp_q[$];
  bit          seg_up = 1'b1;

  always #5 clk = ~clk;

  gray_cnt_src #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
`ifdef GRAY_UPDOWN_EN
    .dir      (dir),
`endif
    .g        (g),
    .g_valid  (g_valid),
    .g_ready  (g_ready),
    .wrap     (wrap)
  );

  // Downstream Gray-to-binary converter: each binary bit is the XOR of all
  // Gray bits at or above it.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] gw);
    logic [N-1:0] b = '0;
    for (int k = 0; k < N; k++) b = b ^ (gw >> k);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected word stream for one segment: consecutive counts modulo 2^N
  // starting from the value the segment was opened with.
  task automatic push_seq(input int unsigned start, input bit up);
    exp_q.delete();
    for (int i = 0; i < SEQ_LEN; i++)
      exp_q.push_back(up ? ((start + i) & MASK) : ((start - i) & MASK));
    seg_up = up;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    dir   = 1'b1;
    tick(n);
    push_seq(0, 1'b1);
    rst_n = 1'b1;
  endtask

  task automatic do_load(input int unsigned v, input bit up);
    bit up_eff;
`ifdef GRAY_UPDOWN_EN
    up_eff = up;
`else
    up_eff = 1'b1;
`endif
    load     = 1'b1;
    load_val = N'(v);
    dir      = up;
    tick(1);
    load = 1'b0;
    push_seq(v, up_eff);
  endtask

  typedef struct {
    logic         rst_n, load, en, ready, gv, wrap;
    logic [N-1:0] load_val, g;
  } smp_t;

  // Monitor: samples on the falling edge and judges each rising edge by the
  // inputs and outputs seen just before it.
  initial begin : monitor
    smp_t        p, c;
    bit          have_p = 1'b0;
    int unsigned w;
    forever begin
      @(negedge clk);
      c.rst_n = rst_n;  c.load = load;  c.en = en;  c.ready = g_ready;
      c.gv = g_valid;   c.wrap = wrap;  c.load_val = load_val;  c.g = g;
      if (have_p) begin
        if (!p.rst_n) begin
          check("rst_g", 32'(c.g), 0);
          check("rst_valid", 32'(c.gv), 0);
          check("rst_wrap", 32'(c.wrap), 0);
        end else if (p.load) begin
          check("load_g", 32'(gray2bin(c.g)), 32'(p.load_val));
          check("load_valid", 32'(c.gv), 0);
          check("load_wrap", 32'(c.wrap), 0);
        end else if (p.gv && p.ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_word: transfer with no expected word queued (t=%0t)", $time);
          end else begin
            w = exp_q.pop_front();
            check("xfer_word", 32'(gray2bin(p.g)), w);
            check("xfer_wrap", 32'(c.wrap), seg_up ? 32'(w == MASK) : 32'(w == 0));
            check("xfer_valid", 32'(c.gv), 32'(p.en));
          end
        end else if (p.gv) begin
          check("hold_g", 32'(c.g), 32'(p.g));
          check("hold_valid", 32'(c.gv), 1);
          check("hold_wrap", 32'(c.wrap), 0);
        end else begin
          check("idle_g", 32'(c.g), 32'(p.g));
          check("idle_valid", 32'(c.gv), 32'(p.en));
          check("idle_wrap", 32'(c.wrap), 0);
        end
      end
      p      = c;
      have_p = 1'b1;
    end
  end

  initial begin : stimulus
    logic [N-1:0] up_seq [5];
    up_seq = '{10'b0000000000, 10'b0000000001, 10'b0000000011,
               10'b0000000010, 10'b0000000110};
    rst_n = 1'b0;  en = 1'b0;  load = 1'b0;  load_val = '0;
    g_ready = 1'b0;  dir = 1'b1;

    do_reset(3);
    check("reset_g", 32'(g), 0);
    check("reset_valid", 32'(g_valid), 0);
    check("reset_wrap", 32'(wrap), 0);

    // Count up, one word per cycle.
    en = 1'b1;  g_ready = 1'b1;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      check("up_seq_g", 32'(g), 32'(up_seq[k]));
      check("up_seq_valid", 32'(g_valid), 1);
      tick(1);
    end

    // Load, then start sending without g changing.
    en = 1'b0;  g_ready = 1'b0;
    do_load(32'b0111000111, 1'b1);
    check("load_dir_g", 32'(g), 32'b0100100100);
    check("load_dir_valid", 32'(g_valid), 0);
    en = 1'b1;
    tick(1);
    check("load_send_g", 32'(g), 32'b0100100100);
    check("load_send_valid", 32'(g_valid), 1);

    // Backpressure with en toggling.
    en = 1'b1;  g_ready = 1'b1;
    do_reset(1);
    tick(3);
    g_ready = 1'b0;
    check("bp_start_g", 32'(g), 32'b0000000011);
    for (int i = 0; i < 3; i++) begin
      en = i[0];
      tick(1);
      check("bp_hold_g", 32'(g), 32'b0000000011);
      check("bp_hold_valid", 32'(g_valid), 1);
    end
    en = 1'b1;  g_ready = 1'b1;
    tick(1);
    check("bp_release_g", 32'(g), 32'b0000000010);

    // Upward wrap.
    en = 1'b0;  g_ready = 1'b0;
    do_load(MASK, 1'b1);
    check("wrap_up_load_g", 32'(g), 32'b1000000000);
    en = 1'b1;  g_ready = 1'b1;
    tick(2);
    check("wrap_up_g", 32'(g), 0);
    check("wrap_up_pulse", 32'(wrap), 1);
    tick(1);
    check("wrap_up_once", 32'(wrap), 0);

`ifdef GRAY_UPDOWN_EN
    // Downward wrap.
    en = 1'b0;  g_ready = 1'b0;
    do_load(0, 1'b0);
    en = 1'b1;  g_ready = 1'b1;
    tick(2);
    check("wrap_dn_g", 32'(g), 32'b1000000000);
    check("wrap_dn_pulse", 32'(wrap), 1);
    tick(1);
    check("wrap_dn_once", 32'(wrap), 0);
`endif

    // Reset while a word is pending.
    en = 1'b1;  g_ready = 1'b0;
    do_load(5, 1'b1);
    tick(1);
    check("pend_valid", 32'(g_valid), 1);
    do_reset(1);
    check("rst_pend_g", 32'(g), 0);
    check("rst_pend_valid", 32'(g_valid), 0);
    check("rst_pend_wrap", 32'(wrap), 0);

    // Load colliding with a transfer at the top count.
    en = 1'b0;  g_ready = 1'b0;
    do_load(MASK, 1'b1);
    en = 1'b1;  g_ready = 1'b1;
    tick(1);
    do_load(32'h2A5, 1'b1);
    check("coll_g", 32'(g), 32'b1111110111);
    check("coll_valid", 32'(g_valid), 0);
    check("coll_wrap", 32'(wrap), 0);

    // Randomized end-to-end run.
    do_reset(2);
    for (int cyc = 0; cyc < 2048; cyc++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_load($urandom() & MASK, 1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 999) == 0) begin
        do_reset(1);
      end else begin
        en      = ($urandom_range(0, 7) != 0);
        g_ready = 1'($urandom_range(0, 1));
        tick(1);
      end
    end

    en = 1'b0;  g_ready = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
